avg_scheduler: RTL

- Shares one sample-averaging datapath between NR_CH independent measurement channels, e.g. the pitch and volume antenna period counters.
- Round-robin arbiter accepts at most one sample per cycle over per-channel valid/ready handshakes.
- Keeps a separate accumulator and sample counter per channel.
- Emits a channel-tagged average once each channel has collected 2^SAMP_LOG2 samples.
- Sits between the period-measurement front ends and the audio/volume mapping logic.

---
 rtl/avg_scheduler.sv | 94 +++++++++
 1 files changed

// File: rtl/avg_scheduler.sv
// Round-robin shared averager: accepts one sample per cycle from NR_CH channels and
// emits a channel-tagged mean once a channel has collected 2^SAMP_LOG2 samples.
module avg_scheduler #(
  parameter int NR_CH     = 2,
  parameter int IO_B      = 16,
  parameter int SAMP_LOG2 = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NR_CH*IO_B-1:0]    ch_data,
  input  logic [NR_CH-1:0]         ch_valid,
  output logic [NR_CH-1:0]         ch_ready,
  input  logic                     cfg_clear,
  output logic [IO_B-1:0]          out_data,
  output logic [$clog2(NR_CH)-1:0] out_ch,
  output logic                     out_valid
);

  localparam int CH_W  = $clog2(NR_CH);
  localparam int ACC_W = IO_B + SAMP_LOG2;

  logic [ACC_W-1:0]     acc [NR_CH];
  logic [SAMP_LOG2-1:0] cnt [NR_CH];
  logic [CH_W-1:0]      last_grant;

  logic                 grant_found;
  logic [CH_W-1:0]      grant_idx;
  logic                 transfer;
  logic [IO_B-1:0]      sel_data;
  logic [ACC_W-1:0]     sum;

  // Two-pass search: channels above last_grant first, then wrap around to 0..last_grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NR_CH; i++) begin
      if (!grant_found && ch_valid[i] && (i > int'(last_grant))) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(i);
      end
    end
    for (int i = 0; i < NR_CH; i++) begin
      if (!grant_found && ch_valid[i] && (i <= int'(last_grant))) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(i);
      end
    end
  end

  // Ready is gated by reset too, so it drops the instant reset asserts.
  always_comb begin
    ch_ready = '0;
    if (grant_found && !cfg_clear && !reset)
      ch_ready = NR_CH'(1) << grant_idx;
  end

  assign transfer = |ch_ready;
  assign sel_data = ch_data[grant_idx*IO_B +: IO_B];
  assign sum      = acc[grant_idx] + ACC_W'(sel_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NR_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
      last_grant <= CH_W'(NR_CH - 1);
      out_data   <= '0;
      out_ch     <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (cfg_clear) begin
        for (int i = 0; i < NR_CH; i++) begin
          acc[i] <= '0;
          cnt[i] <= '0;
        end
      end else if (transfer) begin
        last_grant <= grant_idx;
        if (cnt[grant_idx] == {SAMP_LOG2{1'b1}}) begin
          out_data       <= sum[ACC_W-1:SAMP_LOG2];
          out_ch         <= grant_idx;
          out_valid      <= 1'b1;
          acc[grant_idx] <= '0;
          cnt[grant_idx] <= '0;
        end else begin
          acc[grant_idx] <= sum;
          cnt[grant_idx] <= cnt[grant_idx] + SAMP_LOG2'(1);
        end
      end
    end
  end

endmodule
